// File: rtl/vga_pattern_gen.sv
// VGA timing generator with built-in test patterns.
// Free-running column/row counters drive sync, blanking and a pattern
// generator. Every output is registered one cycle after the counters, so
// sync, colour, active and col/row all describe the same pixel.
module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int COLOR_BITS = 1,
    parameter int CHK_SHIFT  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  active,
    output logic                  frame_start,
    output logic [9:0]            col,
    output logic [9:0]            row
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    // 11-bit constants so comparisons stay exact even when a total is 1024
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] BAR_LAST   = 11'(BAR_W - 1);

    // Timing and pattern state
    logic [9:0] h_cnt_reg, h_cnt_next;
    logic [9:0] v_cnt_reg, v_cnt_next;
    logic [9:0] bar_px_reg, bar_px_next;
    logic [2:0] bar_idx_reg, bar_idx_next;
    logic [1:0] mode_q;
    logic       frame_cnt;

    // Registered outputs
    logic hsync_reg, vsync_reg, active_reg, frame_start_reg;
    logic red_bit_reg, green_bit_reg, blue_bit_reg;
    logic [9:0] col_reg, row_reg;

    // Decoded counter state
    logic [10:0] h_pos, v_pos;
    logic        h_wrap, v_last, frame_wrap;
    logic        visible, hs_on, vs_on;
    logic        pix_r, pix_g, pix_b;

    assign h_pos = {1'b0, h_cnt_reg};
    assign v_pos = {1'b0, v_cnt_reg};

    // Next-state for the column/row counters and the divider-free bar counter
    always_comb begin
        h_wrap       = (h_pos == H_LAST);
        v_last       = (v_pos == V_LAST);
        frame_wrap   = h_wrap && v_last;
        h_cnt_next   = h_cnt_reg + 10'd1;
        v_cnt_next   = v_cnt_reg;
        bar_px_next  = bar_px_reg + 10'd1;
        bar_idx_next = bar_idx_reg;
        if (h_wrap) begin
            h_cnt_next = 10'd0;
            v_cnt_next = v_last ? 10'd0 : v_cnt_reg + 10'd1;
        end
        if (h_wrap) begin
            bar_px_next  = 10'd0;
            bar_idx_next = 3'd0;
        end else if ({1'b0, bar_px_reg} == BAR_LAST) begin
            bar_px_next  = 10'd0;
            // Saturating at bar 7 covers the leftover pixels when H_ACTIVE
            // is not a multiple of 8
            bar_idx_next = (bar_idx_reg == 3'd7) ? 3'd7 : bar_idx_reg + 3'd1;
        end
    end

    // Column/row/bar counters run free, independent of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg   <= 10'd0;
            v_cnt_reg   <= 10'd0;
            bar_px_reg  <= 10'd0;
            bar_idx_reg <= 3'd0;
        end else begin
            h_cnt_reg   <= h_cnt_next;
            v_cnt_reg   <= v_cnt_next;
            bar_px_reg  <= bar_px_next;
            bar_idx_reg <= bar_idx_next;
        end
    end

    // Pattern mode and frame parity only change at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 2'd0;
            frame_cnt <= 1'b0;
        end else if (frame_wrap) begin
            mode_q    <= mode;
            frame_cnt <= ~frame_cnt;
        end
    end

    // Sync windows, visibility and per-channel pattern bit for this pixel
    always_comb begin
        visible = (h_pos < H_ACT) && (v_pos < V_ACT);
        hs_on   = (h_pos >= HS_START) && (h_pos < HS_END);
        vs_on   = (v_pos >= VS_START) && (v_pos < VS_END);
        pix_r   = 1'b0;
        pix_g   = 1'b0;
        pix_b   = 1'b0;
        case (mode_q)
            2'd0: begin
                pix_r = 1'b1;
                pix_g = 1'b1;
                pix_b = 1'b1;
            end
            2'd1: begin
                pix_r = bar_idx_reg[2];
                pix_g = bar_idx_reg[1];
                pix_b = bar_idx_reg[0];
            end
            2'd2: begin
                pix_r = h_cnt_reg[CHK_SHIFT] ^ v_cnt_reg[CHK_SHIFT] ^ frame_cnt;
                pix_g = pix_r;
                pix_b = pix_r;
            end
            default: begin
                pix_r = (v_pos == 11'd0) || (v_pos == V_ACT_LAST) ||
                        (h_pos == 11'd0) || (h_pos == H_ACT_LAST);
                pix_g = pix_r;
                pix_b = pix_r;
            end
        endcase
        if (!(visible && en)) begin
            pix_r = 1'b0;
            pix_g = 1'b0;
            pix_b = 1'b0;
        end
    end

    // Output register stage: one cycle behind the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            active_reg      <= 1'b0;
            frame_start_reg <= 1'b0;
            red_bit_reg     <= 1'b0;
            green_bit_reg   <= 1'b0;
            blue_bit_reg    <= 1'b0;
            col_reg         <= 10'd0;
            row_reg         <= 10'd0;
        end else begin
            hsync_reg       <= hs_on ? HS_POL : ~HS_POL;
            vsync_reg       <= vs_on ? VS_POL : ~VS_POL;
            active_reg      <= visible;
            frame_start_reg <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
            red_bit_reg     <= pix_r;
            green_bit_reg   <= pix_g;
            blue_bit_reg    <= pix_b;
            col_reg         <= h_cnt_reg;
            row_reg         <= v_cnt_reg;
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign active      = active_reg;
    assign frame_start = frame_start_reg;
    assign col         = col_reg;
    assign row         = row_reg;

    // Each colour bit is replicated across the full channel width
    genvar gi;
    generate
        for (gi = 0; gi < COLOR_BITS; gi++) begin : g_color
            assign red[gi]   = red_bit_reg;
            assign green[gi] = green_bit_reg;
            assign blue[gi]  = blue_bit_reg;
        end
    endgenerate

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen. Three instances share clock, reset and
// en: default 640x480 timing (first two lines only), a medium 64x40 raster
// for pattern/mode/en/reset behaviour, and a tiny 16x8 raster in checker mode.
module tb_vga_pattern_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [1:0] mode_d, mode_m, mode_s;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic d_hsync, d_vsync, d_active, d_frame_start;
    logic [0:0] d_red, d_green, d_blue;
    logic [9:0] d_col, d_row;

    vga_pattern_gen u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_d),
        .hsync(d_hsync), .vsync(d_vsync),
        .red(d_red), .green(d_green), .blue(d_blue),
        .active(d_active), .frame_start(d_frame_start),
        .col(d_col), .row(d_row)
    );

    // Medium instance: H 64/4/8/4 (80), V 40/2/2/4 (48), 3840 cycles/frame
    logic m_hsync, m_vsync, m_active, m_frame_start;
    logic [0:0] m_red, m_green, m_blue;
    logic [9:0] m_col, m_row;

    vga_pattern_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) u_med (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_m),
        .hsync(m_hsync), .vsync(m_vsync),
        .red(m_red), .green(m_green), .blue(m_blue),
        .active(m_active), .frame_start(m_frame_start),
        .col(m_col), .row(m_row)
    );

    // Small instance: H 16/2/4/2 (24), V 8/1/2/1 (12), 288 cycles/frame
    logic s_hsync, s_vsync, s_active, s_frame_start;
    logic [3:0] s_red, s_green, s_blue;
    logic [9:0] s_col, s_row;

    vga_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .COLOR_BITS(4), .CHK_SHIFT(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_s),
        .hsync(s_hsync), .vsync(s_vsync),
        .red(s_red), .green(s_green), .blue(s_blue),
        .active(s_active), .frame_start(s_frame_start),
        .col(s_col), .row(s_row)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n           = -1;   // index of the output pixel just presented
    bit stats_on    = 1'b0;

    int m_pos_err = 0, s_pos_err = 0, d_pos_err = 0;
    int m_active_cnt = 0, m_vs_low = 0, m_fs_cnt = 0;
    int d_hs_low = 0, d_hs_first = -1, d_vs_low = 0, d_active_cnt = 0, d_fs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one pixel, sample on the falling edge and update running stats
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
        if (int'(m_col) != n % 80 || int'(m_row) != (n / 80) % 48) m_pos_err++;
        if (int'(s_col) != n % 24 || int'(s_row) != (n / 24) % 12) s_pos_err++;
        if (stats_on) begin
            if (m_frame_start) m_fs_cnt++;
            if (n < 3840) begin
                if (m_active) m_active_cnt++;
                if (!m_vsync) m_vs_low++;
            end
            if (n < 1600) begin
                if (int'(d_col) != n % 800 || int'(d_row) != n / 800) d_pos_err++;
                if (!d_hsync) begin
                    if (d_hs_low == 0) d_hs_first = n;
                    d_hs_low++;
                end
                if (!d_vsync) d_vs_low++;
                if (d_active) d_active_cnt++;
                if (d_frame_start) d_fs_cnt++;
            end
        end
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        mode_d = 2'd0;
        mode_m = 2'd1;
        mode_s = 2'd2;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_hsync", m_hsync, 1);
        chk("rst_vsync", m_vsync, 1);
        chk("rst_red", m_red, 0);
        chk("rst_active", m_active, 0);
        chk("rst_fs", m_frame_start, 0);
        chk("rst_col", m_col, 0);
        chk("rst_row", m_row, 0);
        chk("rst_small_blue", s_blue, 0);

        rst_n    = 1'b1;
        stats_on = 1'b1;
        n        = -1;

        // First edge after release presents pixel (0,0)
        step();
        chk("m0_fs", m_frame_start, 1);
        chk("m0_col", m_col, 0);
        chk("m0_row", m_row, 0);
        chk("m0_white", {m_red, m_green, m_blue}, 3'b111);
        chk("d0_fs", d_frame_start, 1);
        chk("s0_red_solid", s_red, 4'hF);

        // Medium hsync window [68,76)
        run_to(67);  chk("m_hs67", m_hsync, 1);
        run_to(68);  chk("m_hs68", m_hsync, 0);
        run_to(75);  chk("m_hs75", m_hsync, 0);
        run_to(76);  chk("m_hs76", m_hsync, 1);

        // Small checker: frame 1 has frame parity 1, frame 2 parity 0
        run_to(288); chk("s_f1_00_fs", s_frame_start, 1);
                     chk("s_f1_00", s_red, 4'hF);
        run_to(290); chk("s_f1_20", s_blue, 4'h0);
        run_to(576); chk("s_f2_00", s_red, 4'h0);
        run_to(578); chk("s_f2_20", s_green, 4'hF);

        // Default hsync edges and line wrap
        run_to(655); chk("d_hs655", d_hsync, 1);
        run_to(656); chk("d_hs656", d_hsync, 0);
        run_to(751); chk("d_hs751", d_hsync, 0);
        run_to(752); chk("d_hs752", d_hsync, 1);
        run_to(799); chk("d_col799", d_col, 799);
        run_to(800); chk("d_col800", d_col, 0);
                     chk("d_row800", d_row, 1);
        run_to(1600);
        chk("d_hs_low", d_hs_low, 192);
        chk("d_hs_first", d_hs_first, 656);
        chk("d_vs_low", d_vs_low, 0);
        chk("d_active", d_active_cnt, 1280);
        chk("d_fs", d_fs_cnt, 1);
        chk("d_pos", d_pos_err, 0);

        // Medium vsync on rows 42..43
        run_to(3359); chk("m_vs3359", m_vsync, 1);
        run_to(3360); chk("m_vs3360", m_vsync, 0);
                      chk("m_row3360", m_row, 42);
        run_to(3520); chk("m_vs3520", m_vsync, 1);
        run_to(3839); chk("m_fs3839", m_frame_start, 0);
        chk("m_active_frame", m_active_cnt, 2560);
        chk("m_vs_low", m_vs_low, 160);

        // Frame 1: bars (BAR_W = 8), mode 1 latched at the frame boundary
        run_to(3840); chk("m_fs3840", m_frame_start, 1);
                      chk("bar_c0", {m_red, m_green, m_blue}, 3'b000);
        run_to(3848); chk("bar_c8", {m_red, m_green, m_blue}, 3'b001);
        run_to(3856); chk("bar_c16", {m_red, m_green, m_blue}, 3'b010);
        run_to(3872); chk("bar_c32", {m_red, m_green, m_blue}, 3'b100);
        run_to(3903); chk("bar_c63", {m_red, m_green, m_blue}, 3'b111);
        run_to(3904); chk("bar_c64", {m_red, m_green, m_blue}, 3'b000);
                      chk("bar_c64_act", m_active, 0);

        // en low mid-line on row 5
        run_to(4259); chk("en_c19", {m_red, m_green, m_blue}, 3'b010);
        en = 1'b0;
        run_to(4260); chk("en_c20", {m_red, m_green, m_blue}, 3'b000);
                      chk("en_c20_col", m_col, 20);
                      chk("en_c20_act", m_active, 1);
        run_to(4279); chk("en_c39", {m_red, m_green, m_blue}, 3'b000);
        en = 1'b1;
        run_to(4280); chk("en_c40", {m_red, m_green, m_blue}, 3'b101);

        // Mode change at row 10 must not alter the current frame
        run_to(4640);
        mode_m = 2'd3;
        run_to(5448); chk("mid_mode_bar", {m_red, m_green, m_blue}, 3'b001);

        // Frame 2: border
        run_to(7680); chk("m_fs7680", m_frame_start, 1);
        run_to(7710); chk("bd_30_0", m_red, 1);
        run_to(7761); chk("bd_1_1", m_red, 0);
        run_to(9280); chk("bd_0_20", m_green, 1);
        run_to(9310); chk("bd_30_20", m_blue, 0);
        run_to(10863);
        chk("bd_63_39", m_red, 1);
        chk("bd_63_39_col", m_col, 63);
        chk("m_fs_count", m_fs_cnt, 3);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_red", m_red, 0);
        chk("arst_col", m_col, 0);
        chk("arst_row", m_row, 0);
        chk("arst_active", m_active, 0);
        chk("arst_hsync", m_hsync, 1);
        chk("arst_small_col", s_col, 0);
        repeat (2) @(negedge clk);
        stats_on = 1'b0;
        rst_n    = 1'b1;
        n        = -1;

        step();
        chk("r2_fs", m_frame_start, 1);
        chk("r2_col", m_col, 0);
        chk("r2_row", m_row, 0);
        run_to(81);   chk("r2_solid_1_1", m_red, 1);
        run_to(3839); chk("r2_fs3839", m_frame_start, 0);
        run_to(3840); chk("r2_fs3840", m_frame_start, 1);
        run_to(3921); chk("r2_border_1_1", m_red, 0);

        chk("m_pos", m_pos_err, 0);
        chk("s_pos", s_pos_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
